dmem_responder: RTL

- Byte-addressed, little-endian data-memory responder for the pipelined RISC-V core's MEM stage.
- The core's load/store unit acts as initiator with a valid/ready request channel. This block answers on a valid/ready response channel after a programmable latency.
- Replaces the zero-latency combinational data memory so that stall/hazard logic can be exercised.
- Exposes the first eight doublewords as debug outputs for the processor bench.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the load/store unit and the data memory.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  // Load/store unit side.
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side.
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory with programmable response latency.
// Optional macro DMEM_ERR_CHECK_EN: reject misaligned / out-of-range accesses
// with rsp_err; without it addresses wrap byte by byte modulo DEPTH_BYTES.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic [63:0]     element1,
  output logic [63:0]     element2,
  output logic [63:0]     element3,
  output logic [63:0]     element4,
  output logic [63:0]     element5,
  output logic [63:0]     element6,
  output logic [63:0]     element7,
  output logic [63:0]     element8
);

  localparam int unsigned AW       = $clog2(DEPTH_BYTES);
  localparam int unsigned CW       = 4;
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [CW-1:0] CNT_INIT = ZERO_LAT ? CW'(0) : CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_write;
  logic          lat_unsigned;
  logic [1:0]    lat_size;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic          ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [63:0]   rsp_rdata_q;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          acc_write_c;
  logic          acc_unsigned_c;
  logic [1:0]    acc_size_c;
  logic [63:0]   acc_addr_c;
  logic [63:0]   acc_wdata_c;
  logic [3:0]    acc_nbytes_c;
  logic          acc_err_c;
  logic          acc_fire_c;
  logic [AW-1:0] acc_base_c;
  logic [AW:0]   idx_sum_c;
  logic [AW-1:0] byte_idx_c [8];
  logic [63:0]   raw_c;
  logic [63:0]   load_c;
  logic [7:0][63:0] elem_c;

  // Access operands: with zero latency the access happens on the accept edge itself.
  always_comb begin
    if (ZERO_LAT) begin
      acc_write_c    = bus.req_write;
      acc_unsigned_c = bus.req_unsigned;
      acc_size_c     = bus.req_size;
      acc_addr_c     = bus.req_addr;
      acc_wdata_c    = bus.req_wdata;
      acc_fire_c     = (state == IDLE) && bus.req_valid;
    end else begin
      acc_write_c    = lat_write;
      acc_unsigned_c = lat_unsigned;
      acc_size_c     = lat_size;
      acc_addr_c     = lat_addr;
      acc_wdata_c    = lat_wdata;
      acc_fire_c     = (state == WAIT) && (cnt == CW'(0));
    end
  end

  assign acc_nbytes_c = 4'd1 << acc_size_c;

`ifdef DMEM_ERR_CHECK_EN
  // Reject accesses not aligned to their size or running past the end of memory.
  assign acc_err_c = ((acc_addr_c & (64'(acc_nbytes_c) - 64'd1)) != 64'd0) ||
                     (acc_addr_c > (64'(DEPTH_BYTES) - 64'(acc_nbytes_c)));
`else
  assign acc_err_c = 1'b0;
`endif

  // Per-byte memory index; each byte wraps independently past the top of memory.
  always_comb begin
    acc_base_c = AW'(acc_addr_c % 64'(DEPTH_BYTES));
    idx_sum_c  = '0;
    for (int k = 0; k < 8; k++) begin
      idx_sum_c = {1'b0, acc_base_c} + (AW + 1)'(k);
      if (idx_sum_c >= (AW + 1)'(DEPTH_BYTES)) begin
        idx_sum_c = idx_sum_c - (AW + 1)'(DEPTH_BYTES);
      end
      byte_idx_c[k] = AW'(idx_sum_c);
    end
  end

  // Gather the addressed bytes and sign/zero extend to 64 bits.
  always_comb begin
    raw_c = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(acc_nbytes_c)) begin
        raw_c[8*k +: 8] = mem[byte_idx_c[k]];
      end
    end
    case (acc_size_c)
      2'd0:    load_c = acc_unsigned_c ? {56'd0, raw_c[7:0]}  : {{56{raw_c[7]}},  raw_c[7:0]};
      2'd1:    load_c = acc_unsigned_c ? {48'd0, raw_c[15:0]} : {{48{raw_c[15]}}, raw_c[15:0]};
      2'd2:    load_c = acc_unsigned_c ? {32'd0, raw_c[31:0]} : {{32{raw_c[31]}}, raw_c[31:0]};
      default: load_c = raw_c;
    endcase
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write    <= bus.req_write;
            lat_unsigned <= bus.req_unsigned;
            lat_size     <= bus.req_size;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
            ready_q      <= 1'b0;
            if (ZERO_LAT) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= acc_err_c;
              rsp_rdata_q <= (acc_write_c || acc_err_c) ? 64'd0 : load_c;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != CW'(0)) begin
            cnt <= cnt - CW'(1);
          end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err_c;
            rsp_rdata_q <= (acc_write_c || acc_err_c) ? 64'd0 : load_c;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Memory array: cleared on reset, written only by an accepted, error-free store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
        mem[i] <= '0;
      end
    end else if (acc_fire_c && acc_write_c && !acc_err_c) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(acc_nbytes_c)) begin
          mem[byte_idx_c[k]] <= acc_wdata_c[8*k +: 8];
        end
      end
    end
  end

  // Debug view of the first eight doublewords.
  always_comb begin
    for (int e = 0; e < 8; e++) begin
      for (int b = 0; b < 8; b++) begin
        elem_c[e][8*b +: 8] = mem[8*e + b];
      end
    end
  end

  // req_ready is held low while reset is asserted and rises as soon as it releases.
  assign bus.req_ready = ready_q & reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign element1 = elem_c[0];
  assign element2 = elem_c[1];
  assign element3 = elem_c[2];
  assign element4 = elem_c[3];
  assign element5 = elem_c[4];
  assign element6 = elem_c[5];
  assign element7 = elem_c[6];
  assign element8 = elem_c[7];

endmodule
